// File: rtl/serial_modn_pkg.sv
// Shared types and elaboration helpers for the serial remainder engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_modn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunks in one operand.
    function automatic int calc_n(input int width, input int bpc);
        return (bpc > 0) ? (width / bpc) : 1;
    endfunction

    // Remainder register width.
    function automatic int calc_rw(input int modulus);
        return $clog2(modulus);
    endfunction

    // Chunk counter width, able to hold 0..n.
    function automatic int calc_iw(input int n);
        return $clog2(n + 1);
    endfunction

    // WIDTH must exceed BPC so the quotient shift has a retained field.
    function automatic bit params_ok(input int width, input int modulus, input int bpc);
        return (bpc >= 1) && (bpc <= 4) && (modulus >= 2) &&
               (width > bpc) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/serial_modn_if.sv
// Operand/result bundle of the serial remainder engine.
// Latency: n/a (wires only).
// Backpressure: none; e is a level start/hold, outputs are registered status.
// Signals: x operand, e enable, s remainder, f finished, i chunk count,
//          busy run flag, q quotient (only with SERIAL_MODN_QUOT_EN).
interface serial_modn_if #(
    parameter int WIDTH = 64,
    parameter int RW    = 2,
    parameter int IW    = 7
);
    import serial_modn_pkg::*;

    logic [WIDTH-1:0] x;
    logic             e;
    logic [RW-1:0]    s;
    logic             f;
    logic [IW-1:0]    i;
    logic             busy;
`ifdef SERIAL_MODN_QUOT_EN
    logic [WIDTH-1:0] q;
`endif

    // master drives operand and enable; slave is the engine.
    modport master (
        output x, e,
`ifdef SERIAL_MODN_QUOT_EN
        input  q,
`endif
        input  s, f, i, busy
    );

    modport slave (
        input  x, e,
`ifdef SERIAL_MODN_QUOT_EN
        output q,
`endif
        output s, f, i, busy
    );

endinterface

// File: rtl/serial_modn_step.sv
// One Horner step: (r, chunk) -> (r*2^BPC + chunk) mod MODULUS and quotient digit.
// Latency: combinational.
// Backpressure: none.
// Ports: r current remainder, chunk next BPC operand bits, r_nxt new remainder,
//        qd quotient digit of this step.
module modn_step
    import serial_modn_pkg::*;
#(
    parameter int MODULUS = 3,
    parameter int BPC     = 1,
    parameter int RW      = 2
) (
    input  logic [RW-1:0]  r,
    input  logic [BPC-1:0] chunk,
    output logic [RW-1:0]  r_nxt,
    output logic [BPC-1:0] qd
);
    localparam int TW = RW + BPC;
    localparam logic [TW-1:0] MW = TW'(MODULUS);

    logic [TW-1:0] w_rem;
    logic [TW-1:0] w_sub;

    // Restoring division by a constant: since r < MODULUS the partial
    // value is below MODULUS*2^BPC, so BPC compare/subtract stages suffice.
    always_comb begin
        w_rem = {r, chunk};
        w_sub = '0;
        qd    = '0;
        for (int k = BPC - 1; k >= 0; k--) begin
            w_sub = MW << k;
            if (w_rem >= w_sub) begin
                w_rem = w_rem - w_sub;
                qd[k] = 1'b1;
            end
        end
        r_nxt = w_rem[RW-1:0];
    end

endmodule

// File: rtl/serial_modn.sv
// Serial MSB-first residue engine: s = x mod MODULUS, BPC bits per cycle (optional quotient q
// with SERIAL_MODN_QUOT_EN). Latency: start edge + WIDTH/BPC run edges, f high after edge N+1.
// Backpressure: level enable e; dropping e aborts a run or releases DONE back to IDLE.
// Ports: clk, rst_n (async active-low), bus (serial_modn_if.slave: x, e, s, f, i, busy[, q]).
module serial_modn #(
    parameter int WIDTH   = 64,
    parameter int MODULUS = 3,
    parameter int BPC     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_modn_if.slave  bus
);
    import serial_modn_pkg::*;

    localparam int N  = calc_n(WIDTH, BPC);
    localparam int RW = calc_rw(MODULUS);
    localparam int IW = calc_iw(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (!params_ok(WIDTH, MODULUS, BPC)) begin : g_param_err
        $error("serial_modn: illegal WIDTH/MODULUS/BPC combination");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [RW-1:0]    r_rem;
    logic [IW-1:0]    r_cnt;
    logic             r_f;
    logic             r_busy;

    logic [BPC-1:0]   w_chunk;
    logic [RW-1:0]    w_r_nxt;
    logic [BPC-1:0]   w_qd;

    assign w_chunk = r_sh[WIDTH-1 -: BPC];

    modn_step #(
        .MODULUS (MODULUS),
        .BPC     (BPC),
        .RW      (RW)
    ) u_step (
        .r     (r_rem),
        .chunk (w_chunk),
        .r_nxt (w_r_nxt),
        .qd    (w_qd)
    );

`ifdef SERIAL_MODN_QUOT_EN
    logic [WIDTH-1:0] r_q;
    assign bus.q = r_q;
`else
    logic w_unused_qd;
    assign w_unused_qd = ^w_qd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_f     <= 1'b0;
            r_busy  <= 1'b0;
`ifdef SERIAL_MODN_QUOT_EN
            r_q     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_f <= 1'b0;
                    if (bus.e) begin
                        r_sh    <= bus.x;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
`ifdef SERIAL_MODN_QUOT_EN
                        r_q     <= '0;
`endif
                    end else begin
                        // s and q keep the last result while idle.
                        r_cnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (!bus.e) begin
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`ifdef SERIAL_MODN_QUOT_EN
                        r_q     <= '0;
`endif
                    end else begin
                        r_sh  <= r_sh << BPC;
                        r_rem <= w_r_nxt;
                        r_cnt <= r_cnt + 1'b1;
`ifdef SERIAL_MODN_QUOT_EN
                        r_q   <= {r_q[WIDTH-BPC-1:0], w_qd};
`endif
                        // The edge consuming the last chunk also raises f,
                        // so f and busy swap in the same cycle.
                        if (r_cnt == LAST) begin
                            r_busy  <= 1'b0;
                            r_f     <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results frozen until e drops; no restart from DONE.
                    if (!bus.e) begin
                        r_f     <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s    = r_rem;
    assign bus.f    = r_f;
    assign bus.i    = r_cnt;
    assign bus.busy = r_busy;

endmodule
